var_bw_mul_acc: RTL and testbench
=================================

Name: var_bw_mul_acc

Overview:
Downstream accumulator stage for the variable bit-width multiplier. It consumes the multiplier's 32-bit product stream and sums a programmed number of products into a result. In 16-bit mode the result is one 40-bit sum. In parallel mode it is two independent 20-bit lane sums. Each result is handed off to the next stage with a valid/ready handshake.

Parameters:
CNT_W, 8, width of burst length; max products per burst = 2^CNT_W - 1
LANE_W, 20, width of one lane accumulator in parallel mode; full accumulator width = 2*LANE_W

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a burst; honoured only in IDLE
para_mode  input  1  sampled with start; 1 = two 8-bit lanes, 0 = one 16-bit product
len  input  CNT_W  sampled with start; number of products in the burst
p  input  32  product from multiplier
p_valid  input  1  p is valid this cycle
p_ready  output  1  accumulator accepts p this cycle
res  output  2*LANE_W  result; para: {lane1, lane0}; full: single sum
res_valid  output  1  res is valid and held
res_ready  input  1  downstream accepts res
res_ovf  output  1  sticky overflow seen during the burst
busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (async assert, sync deassert assumed upstream): state=IDLE, acc=0, count=0, mode=0, p_ready=0, res_valid=0, res=0, res_ovf=0, busy=0.
- Reset mid-burst aborts immediately. Partial sums are discarded and nothing is emitted.
- FSM states: IDLE, ACCUM, DONE.
- IDLE -> ACCUM:
  - Condition: start=1 and len!=0.
  - Actions: latch mode and len; clear acc, count and ovf.
- IDLE -> DONE:
  - Condition: start=1 and len==0.
  - Actions: clear acc and ovf. Result is 0 with res_valid asserted next cycle.
- start outside IDLE is ignored. mode and len never change mid-burst.
- ACCUM: p_ready=1. A transfer occurs when p_valid && p_ready.
- Full mode per transfer: acc = acc + zero_ext(p) over 2*LANE_W bits.
- Para mode per transfer:
  - lane0 = lane0 + p[15:0]
  - lane1 = lane1 + p[31:16]
  - Each lane is LANE_W bits with no carry between lanes.
- Overflow:
  - Any carry out of the active sum (full sum, or either lane) sets res_ovf.
  - res_ovf is sticky until the next start.
  - Default behaviour is wrap modulo 2^width.
- count increments per transfer. On the transfer where count reaches len: go to DONE, and p_ready drops the next cycle.
- Latency: res_valid is high the cycle after the last transfer. res reflects all len products.
- DONE:
  - res_valid=1, p_ready=0; res and res_ovf are held stable.
  - res_valid && res_ready -> IDLE, with res_valid low the next cycle.
  - res_ready may be held high in advance; the handoff then costs 1 cycle in DONE.
- p_valid outside ACCUM is ignored; p is not consumed.
- Back-to-back bursts: start is accepted on the first IDLE cycle after the DONE handoff.

Optional Feature:
VAR_BW_ACC_SAT_EN
- Defined: on overflow, the affected sum (full sum, or the individual lane) clamps to all-ones and stays clamped for the rest of the burst. res_ovf is set.
- Undefined: sums wrap modulo 2^width. res_ovf is still reported.
- All ports are identical in both builds.

Test Plan:
- Full mode, start with len=3, products 0x0000_0010, 0x0001_0000, 0xFFFF_FFFF -> res=0x01_0001_000F, res_ovf=0, res_valid exactly 1 cycle after the 3rd transfer.
- Para mode, len=2, products 0x0003_0005, 0x0004_0006 -> lane1=7, lane0=11, res=0x00007_0000B; no carry crosses lanes.
- Para mode, len=17, each p=0xFFFF_FFFF:
  - Wrap build: each lane = 17*0xFFFF mod 2^20 = 0x0FFEF, res_ovf=1.
  - VAR_BW_ACC_SAT_EN build: each lane = 0xFFFFF, res_ovf=1.
- Handshake: p_valid toggled randomly during the burst and res_ready held low for 5 cycles in DONE -> res stable throughout, p_ready=0 in DONE, start pulses during the burst ignored, return to IDLE on the res_ready cycle.
- len=0 with start -> res=0, res_valid the next cycle, no p consumed.
- rst_n asserted mid-burst after 2 of 4 transfers -> all outputs at reset values immediately. A subsequent burst with len=1, p=0x5 gives res=5.

Source files
------------

// File: rtl/var_bw_mul_acc.sv
// Accumulator stage behind the variable bit-width multiplier.
// Optional saturation: define VAR_BW_ACC_SAT_EN (default wraps).
module var_bw_mul_acc #(
  parameter int CNT_W  = 8,
  parameter int LANE_W = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  para_mode,
  input  logic [CNT_W-1:0]      len,
  input  logic [31:0]           p,
  input  logic                  p_valid,
  output logic                  p_ready,
  output logic [2*LANE_W-1:0]   res,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_ovf,
  output logic                  busy
);

  localparam int AW = 2 * LANE_W;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           state;
  logic             mode;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] count;
  logic [AW-1:0]    acc;
  logic             ovf;

  logic             xfer;
  logic [CNT_W-1:0] count_nx;
  logic             last;

  logic [AW:0]       full_sum;
  logic [LANE_W:0]   l0_sum;
  logic [LANE_W:0]   l1_sum;
  logic [AW-1:0]     full_new;
  logic [LANE_W-1:0] l0_new;
  logic [LANE_W-1:0] l1_new;
  logic              full_c;
  logic              l0_c;
  logic              l1_c;
  logic [AW-1:0]     acc_nx;
  logic              carry;

  assign xfer     = p_ready & p_valid;
  assign count_nx = count + CNT_W'(1);
  assign last     = (count_nx == len_q);

  // Carry-out of each candidate sum is kept as the extra top bit.
  assign full_sum = {1'b0, acc} + (AW+1)'(p);
  assign l0_sum   = {1'b0, acc[LANE_W-1:0]} + (LANE_W+1)'(p[15:0]);
  assign l1_sum   = {1'b0, acc[AW-1:LANE_W]} + (LANE_W+1)'(p[31:16]);

  assign full_c = full_sum[AW];
  assign l0_c   = l0_sum[LANE_W];
  assign l1_c   = l1_sum[LANE_W];

`ifdef VAR_BW_ACC_SAT_EN
  // A clamped sum stays all-ones: any further non-zero add carries again.
  assign full_new = full_c ? {AW{1'b1}} : full_sum[AW-1:0];
  assign l0_new   = l0_c ? {LANE_W{1'b1}} : l0_sum[LANE_W-1:0];
  assign l1_new   = l1_c ? {LANE_W{1'b1}} : l1_sum[LANE_W-1:0];
`else
  assign full_new = full_sum[AW-1:0];
  assign l0_new   = l0_sum[LANE_W-1:0];
  assign l1_new   = l1_sum[LANE_W-1:0];
`endif

  assign acc_nx = mode ? {l1_new, l0_new} : full_new;
  assign carry  = mode ? (l0_c | l1_c) : full_c;

  assign res     = acc;
  assign res_ovf = ovf;

  // Burst control, accumulation and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode      <= 1'b0;
      len_q     <= '0;
      count     <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      p_ready   <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mode  <= para_mode;
            len_q <= len;
            count <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            if (len != '0) begin
              state   <= ACCUM;
              p_ready <= 1'b1;
            end else begin
              state     <= DONE;
              res_valid <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc   <= acc_nx;
            ovf   <= ovf | carry;
            count <= count_nx;
            if (last) begin
              state     <= DONE;
              p_ready   <= 1'b0;
              res_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          p_ready   <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_var_bw_mul_acc.sv
// Randomised bench for var_bw_mul_acc.
// Transaction-level sum model plus literal result checks.
module tb_var_bw_mul_acc;

  localparam int CNT_W  = 8;
  localparam int LANE_W = 20;
  localparam int AW     = 2 * LANE_W;
  localparam longint LMAX = (64'd1 << LANE_W) - 1;
  localparam longint FMAX = (64'd1 << AW) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             para_mode = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic [31:0]      p = '0;
  logic             p_valid = 1'b0;
  logic             p_ready;
  logic [AW-1:0]    res;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic             res_ovf;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  var_bw_mul_acc #(.CNT_W(CNT_W), .LANE_W(LANE_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .para_mode(para_mode), .len(len), .p(p),
    .p_valid(p_valid), .p_ready(p_ready), .res(res),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_ovf(res_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Model: phase 0 idle, 1 collecting, 2 result offered.
  int         ph = 0;
  bit         m_mode = 0;
  int         m_len = 0;
  int         m_cnt = 0;
  longint     s_full = 0;
  longint     s0 = 0;
  longint     s1 = 0;

  function automatic longint lane_val(input longint s);
`ifdef VAR_BW_ACC_SAT_EN
    return (s > LMAX) ? LMAX : s;
`else
    return s & LMAX;
`endif
  endfunction

  function automatic longint full_val(input longint s);
`ifdef VAR_BW_ACC_SAT_EN
    return (s > FMAX) ? FMAX : s;
`else
    return s & FMAX;
`endif
  endfunction

  function automatic logic [63:0] exp_res();
    if (m_mode)
      return (lane_val(s1) << LANE_W) | lane_val(s0);
    return full_val(s_full);
  endfunction

  function automatic logic exp_ovf();
    if (m_mode)
      return (s0 > LMAX) || (s1 > LMAX);
    return s_full > FMAX;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0;
    end else begin
      case (ph)
        0: if (start) begin
          m_mode = para_mode;
          m_len  = int'(len);
          m_cnt  = 0;
          s_full = 0;
          s0     = 0;
          s1     = 0;
          ph     = (len == 0) ? 2 : 1;
        end
        1: if (p_valid) begin
          s_full += longint'(p);
          s0     += longint'(p[15:0]);
          s1     += longint'(p[31:16]);
          m_cnt++;
          if (m_cnt == m_len) ph = 2;
        end
        2: if (res_ready) ph = 0;
        default: ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("p_ready", 64'(p_ready), 64'(ph == 1));
      chk("res_valid", 64'(res_valid), 64'(ph == 2));
      chk("busy", 64'(busy), 64'(ph != 0));
      if (ph == 2) begin
        chk("res", 64'(res), exp_res());
        chk("res_ovf", 64'(res_ovf), 64'(exp_ovf()));
      end
    end
  end

  task automatic run_burst(input bit md,
                           input int n,
                           input logic [31:0] pr[$],
                           input int rdy_delay,
                           input bit rnd,
                           output logic [AW-1:0] r,
                           output logic ov);
    int idx;
    int guard;
    int waited;
    bit x;
    bit hs;
    r  = '0;
    ov = 1'b0;
    start     = 1'b1;
    para_mode = md;
    len       = CNT_W'(n);
    res_ready = (rdy_delay == 0);
    @(posedge clk); #1;
    start = 1'b0;
    idx   = 0;
    guard = 0;
    while (idx < n && guard < 2000) begin
      p_valid   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      p         = pr[idx];
      start     = ($urandom_range(0, 3) == 0);
      len       = CNT_W'($urandom);
      para_mode = 1'($urandom);
      x = p_valid && p_ready;
      @(posedge clk); #1;
      if (x) idx++;
      guard++;
    end
    if (idx < n) chk("xfer_timeout", 64'(idx), 64'(n));
    start   = 1'b0;
    waited  = 0;
    guard   = 0;
    hs      = 1'b0;
    while (!hs && guard < 200) begin
      p_valid   = 1'($urandom);
      p         = $urandom;
      res_ready = (waited >= rdy_delay);
      hs = res_valid && res_ready;
      if (hs) begin
        r  = res;
        ov = res_ovf;
      end
      @(posedge clk); #1;
      if (res_valid) waited++;
      guard++;
    end
    if (!hs) chk("done_timeout", 64'(0), 64'(1));
    p_valid   = 1'b0;
    res_ready = 1'b0;
  endtask

  logic [31:0]   q[$];
  logic [AW-1:0] r;
  logic          ov;
  logic [63:0]   pe;

  initial begin
    #2 rst_n = 1'b0;
    #1 mon_en = 1'b1;
    chk("rst_res", 64'(res), 64'(0));
    chk("rst_ovf", 64'(res_ovf), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    q = '{32'h0000_0010, 32'h0001_0000, 32'hFFFF_FFFF};
    run_burst(1'b0, 3, q, 0, 1'b0, r, ov);
    chk("full3_res", 64'(r), 64'h01_0001_000F);
    chk("full3_ovf", 64'(ov), 64'(0));

    q = '{32'h0003_0005, 32'h0004_0006};
    run_burst(1'b1, 2, q, 2, 1'b0, r, ov);
    chk("para2_res", 64'(r), 64'h00007_0000B);

    q = {};
    for (int i = 0; i < 17; i++) q.push_back(32'hFFFF_FFFF);
    run_burst(1'b1, 17, q, 5, 1'b1, r, ov);
`ifdef VAR_BW_ACC_SAT_EN
    pe = 64'hFFFFF_FFFFF;
`else
    pe = 64'h0FFEF_0FFEF;
`endif
    chk("para17_res", 64'(r), pe);
    chk("para17_ovf", 64'(ov), 64'(1));

    q = {};
    run_burst(1'b0, 0, q, 1, 1'b0, r, ov);
    chk("len0_res", 64'(r), 64'(0));

    for (int b = 0; b < 14; b++) begin
      int n;
      bit md;
      md = 1'($urandom);
      n  = $urandom_range(1, 24);
      q  = {};
      for (int i = 0; i < n; i++)
        q.push_back(($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom);
      run_burst(md, n, q, $urandom_range(0, 5), 1'b1, r, ov);
    end

    start = 1'b1;
    para_mode = 1'b0;
    len = CNT_W'(4);
    @(posedge clk); #1;
    start = 1'b0;
    p_valid = 1'b1;
    p = 32'h1234;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    p_valid = 1'b0;
    #1;
    chk("abort_p_ready", 64'(p_ready), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_res", 64'(res), 64'(0));
    chk("abort_valid", 64'(res_valid), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    q = '{32'h5};
    run_burst(1'b0, 1, q, 0, 1'b0, r, ov);
    chk("post_rst_res", 64'(r), 64'(5));

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
